// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch types, ARMv8 condition codes
// and NZCV flag bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_UNCOND = 3'd1,
    BR_CBZ    = 3'd2,
    BR_CBNZ   = 3'd3,
    BR_BCOND  = 3'd4
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// ARMv8 condition-code evaluator against an NZCV nibble.
// Shared by B.cond and CSEL.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;
  logic base;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  // Even codes test a predicate; odd codes invert it, except AL/NV.
  always_comb begin
    base = 1'b0;
    case (cond_i[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
  end

  assign pass_o = (cond_i[3:1] == 3'b111) ? 1'b1
                                          : (base ^ cond_i[0]);

endmodule

// File: rtl/ex_flags_stage.sv
// Execute-stage tail: NZCV flags register, branch decision
// and the EX/MEM pipeline register.
module ex_flags_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             set_flags,
  input  logic             flag_arith,
  input  logic [2:0]       br_type,
  input  logic [3:0]       cond,
  input  logic [REGW-1:0]  rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] store_data,
  output logic             br_taken,
  output logic [3:0]       flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_store_data,
  output logic [REGW-1:0]  out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write
);

  logic [3:0]       flags_q, flags_d;
  logic             valid_q;
  logic [WIDTH-1:0] result_q, sdata_q;
  logic [REGW-1:0]  rd_q;
  logic             rw_q, mr_q, mw_q;
  logic             upd;
  logic             live;
  logic             cond_pass;

  assign upd  = in_valid & ~flush & ~stall;
  assign live = in_valid & ~flush;

  cond_eval u_cond (
    .cond_i (cond),
    .nzcv_i (flags_q),
    .pass_o (cond_pass)
  );

  // Branch decision; B.cond sees only the registered flags.
  always_comb begin
    br_taken = 1'b0;
    if (live) begin
      case (br_type_e'(br_type))
        BR_UNCOND: br_taken = 1'b1;
        BR_CBZ:    br_taken = alu_zero;
        BR_CBNZ:   br_taken = ~alu_zero;
        BR_BCOND:  br_taken = cond_pass;
        default:   br_taken = 1'b0;
      endcase
    end
  end

  // Next NZCV; logic ops clear C and V.
  always_comb begin
    flags_d = flags_q;
    if (upd && set_flags) begin
      flags_d[FLAG_N] = alu_negative;
      flags_d[FLAG_Z] = alu_zero;
      flags_d[FLAG_C] = flag_arith & alu_carry_out;
      flags_d[FLAG_V] = flag_arith & alu_overflow;
    end
  end

  // Flags register.
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  // EX/MEM register; flush beats stall and inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else if (!stall) begin
      valid_q  <= in_valid;
      result_q <= alu_result;
      sdata_q  <= store_data;
      rd_q     <= rd;
      rw_q     <= reg_write & in_valid;
      mr_q     <= mem_read & in_valid;
      mw_q     <= mem_write & in_valid;
    end
  end

  assign flags          = flags_q;
  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_store_data = sdata_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = rw_q;
  assign out_mem_read   = mr_q;
  assign out_mem_write  = mw_q;

endmodule

// File: tb/tb_ex_flags_stage.sv
// Bench for ex_flags_stage: directed scenarios plus a
// randomized run against a behavioural model.
module tb_ex_flags_stage;

  localparam int WIDTH = 64;
  localparam int REGW  = 5;

  logic             clk = 1'b0;
  logic             reset, stall, flush, in_valid;
  logic [WIDTH-1:0] alu_result, store_data;
  logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic             set_flags, flag_arith;
  logic [2:0]       br_type;
  logic [3:0]       cond;
  logic [REGW-1:0]  rd;
  logic             reg_write, mem_read, mem_write;
  logic             br_taken;
  logic [3:0]       flags;
  logic             out_valid;
  logic [WIDTH-1:0] out_result, out_store_data;
  logic [REGW-1:0]  out_rd;
  logic             out_reg_write, out_mem_read, out_mem_write;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [3:0]       m_flags;
  logic             m_valid, m_rw, m_mr, m_mw;
  logic [WIDTH-1:0] m_result, m_sd;
  logic [REGW-1:0]  m_rd;

  always #5 clk = ~clk;

  ex_flags_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .set_flags(set_flags), .flag_arith(flag_arith),
    .br_type(br_type), .cond(cond), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .store_data(store_data),
    .br_taken(br_taken), .flags(flags), .out_valid(out_valid),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
  );

  // Condition truth table written straight from the ARMv8 list.
  function automatic logic ref_cond(input logic [3:0] c,
                                    input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic ref_br();
    if (!(in_valid && !flush)) return 1'b0;
    case (br_type)
      3'd1: return 1'b1;
      3'd2: return alu_zero;
      3'd3: return !alu_zero;
      3'd4: return ref_cond(cond, m_flags);
      default: return 1'b0;
    endcase
  endfunction

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    logic [3:0]       nf;
    logic             nv, nrw, nmr, nmw;
    logic [WIDTH-1:0] nr, ns;
    logic [REGW-1:0]  nd;
    nf = m_flags; nv = m_valid; nr = m_result; ns = m_sd;
    nd = m_rd; nrw = m_rw; nmr = m_mr; nmw = m_mw;
    if (reset) begin
      nf = 4'b0; nv = 0; nr = 0; ns = 0; nd = 0;
      nrw = 0; nmr = 0; nmw = 0;
    end else begin
      if (in_valid && !flush && !stall && set_flags)
        nf = {alu_negative, alu_zero,
              flag_arith ? alu_carry_out : 1'b0,
              flag_arith ? alu_overflow : 1'b0};
      if (flush) begin
        nv = 0; nrw = 0; nmr = 0; nmw = 0;
      end else if (!stall) begin
        nv = in_valid; nr = alu_result; ns = store_data;
        nd = rd;
        nrw = reg_write && in_valid;
        nmr = mem_read && in_valid;
        nmw = mem_write && in_valid;
      end
    end
    @(posedge clk);
    #1;
    m_flags = nf; m_valid = nv; m_result = nr; m_sd = ns;
    m_rd = nd; m_rw = nrw; m_mr = nmr; m_mw = nmw;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; in_valid = 0;
    alu_result = '0; store_data = '0;
    alu_negative = 0; alu_zero = 0; alu_overflow = 0;
    alu_carry_out = 0; set_flags = 0; flag_arith = 0;
    br_type = 3'd0; cond = 4'd0; rd = '0;
    reg_write = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; in_valid = 1; set_flags = 1; flag_arith = 1;
    alu_negative = 1; alu_zero = 1; alu_carry_out = 1;
    alu_overflow = 1; reg_write = 1; mem_read = 1; mem_write = 1;
    tick();
    tick();
    total++;
    if (flags !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", flags);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    total++;
    if ({out_reg_write, out_mem_read, out_mem_write} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b%b exp=000",
               out_reg_write, out_mem_read, out_mem_write);
    end
    total++;
    if (out_result !== '0 || out_rd !== '0 || out_store_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%0d exp=0/0",
                      out_result, out_rd);
    end
    idle();
    tick();
  endtask

  task automatic test_subs_blt();
    idle();
    in_valid = 1; alu_result = 64'hFFFF_FFFF_FFFF_FFE7;
    alu_negative = 1; set_flags = 1; flag_arith = 1;
    tick();
    total++;
    if (flags !== 4'b1000) begin
      bad++; $display("FAIL subs_flags got=%b exp=1000", flags);
    end
    set_flags = 0; alu_negative = 0;
    br_type = 3'd4; cond = 4'b1011;
    #1;
    total++;
    if (br_taken !== 1'b1) begin
      bad++; $display("FAIL blt_taken got=%b exp=1", br_taken);
    end
    cond = 4'b1010;
    #1;
    total++;
    if (br_taken !== 1'b0) begin
      bad++; $display("FAIL bge_taken got=%b exp=0", br_taken);
    end
    tick();
  endtask

  task automatic test_ands_logic();
    idle();
    in_valid = 1; set_flags = 1; flag_arith = 0;
    alu_zero = 1; alu_carry_out = 1; alu_overflow = 1;
    tick();
    total++;
    if (flags !== 4'b0100) begin
      bad++; $display("FAIL ands_flags got=%b exp=0100", flags);
    end
    set_flags = 0; br_type = 3'd4; cond = 4'b0000;
    #1;
    total++;
    if (br_taken !== 1'b1) begin
      bad++; $display("FAIL beq_taken got=%b exp=1", br_taken);
    end
    cond = 4'b0010;
    #1;
    total++;
    if (br_taken !== 1'b0) begin
      bad++; $display("FAIL bcs_taken got=%b exp=0", br_taken);
    end
    tick();
  endtask

  task automatic test_cbz_cbnz();
    logic [3:0] f0;
    idle();
    f0 = flags;
    in_valid = 1; alu_zero = 1; br_type = 3'd2;
    #1;
    total++;
    if (br_taken !== 1'b1) begin
      bad++; $display("FAIL cbz_taken got=%b exp=1", br_taken);
    end
    br_type = 3'd3;
    #1;
    total++;
    if (br_taken !== 1'b0) begin
      bad++; $display("FAIL cbnz_taken got=%b exp=0", br_taken);
    end
    tick();
    in_valid = 0; br_type = 3'd2;
    #1;
    total++;
    if (br_taken !== 1'b0) begin
      bad++; $display("FAIL cbz_invalid got=%b exp=0", br_taken);
    end
    tick();
    total++;
    if (flags !== f0) begin
      bad++; $display("FAIL cb_flags_held got=%b exp=%b", flags, f0);
    end
  endtask

  task automatic test_stall_flush();
    logic [3:0] f0;
    idle();
    in_valid = 1; alu_result = 64'd75; rd = 5'd5; reg_write = 1;
    tick();
    f0 = flags;
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'd75 ||
        out_rd !== 5'd5 || out_reg_write !== 1'b1) begin
      bad++;
      $display("FAIL load75 got=v%b r%0d rd%0d w%b exp=v1 r75 rd5 w1",
               out_valid, out_result, out_rd, out_reg_write);
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1; set_flags = 1; flag_arith = 1;
      alu_negative = 1; alu_zero = 1; alu_carry_out = 1;
      alu_result = {$urandom, $urandom}; rd = 5'($urandom);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_result !== 64'd75 ||
          out_rd !== 5'd5 || flags !== f0) begin
        bad++;
        $display("FAIL stall_hold%0d got=v%b r%0d f%b exp=v1 r75 f%b",
                 i, out_valid, out_result, flags, f0);
      end
    end
    flush = 1; stall = 1; set_flags = 1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0 ||
        flags !== f0) begin
      bad++;
      $display("FAIL flush_stall got=v%b w%b f%b exp=v0 w0 f%b",
               out_valid, out_reg_write, flags, f0);
    end
    idle();
    tick();
  endtask

  task automatic test_overflow();
    idle();
    in_valid = 1; set_flags = 1; flag_arith = 1;
    alu_overflow = 1; alu_carry_out = 1;
    alu_result = 64'h8000_0000_0000_0000;
    tick();
    total++;
    if (flags !== 4'b0011) begin
      bad++; $display("FAIL adds_flags got=%b exp=0011", flags);
    end
    set_flags = 0; br_type = 3'd4;
    cond = 4'b0110;
    #1;
    total++;
    if (br_taken !== 1'b1) begin
      bad++; $display("FAIL bvs_taken got=%b exp=1", br_taken);
    end
    cond = 4'b1000;
    #1;
    total++;
    if (br_taken !== 1'b1) begin
      bad++; $display("FAIL bhi_taken got=%b exp=1", br_taken);
    end
    cond = 4'b1101;
    #1;
    total++;
    if (br_taken !== 1'b1) begin
      bad++; $display("FAIL ble_taken got=%b exp=1", br_taken);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      alu_result = {$urandom, $urandom};
      store_data = {$urandom, $urandom};
      {alu_negative, alu_zero, alu_overflow, alu_carry_out} =
        4'($urandom);
      set_flags = $urandom_range(0, 1);
      flag_arith = $urandom_range(0, 1);
      br_type = 3'($urandom_range(0, 7));
      cond = 4'($urandom);
      rd = 5'($urandom);
      {reg_write, mem_read, mem_write} = 3'($urandom);
      #1;
      total++;
      if (br_taken !== ref_br()) begin
        bad++;
        $display("FAIL rnd_br[%0d] got=%b exp=%b bt=%0d c=%b f=%b",
                 i, br_taken, ref_br(), br_type, cond, m_flags);
      end
      tick();
      total++;
      if (flags !== m_flags || out_valid !== m_valid ||
          {out_reg_write, out_mem_read, out_mem_write} !==
          {m_rw, m_mr, m_mw}) begin
        bad++;
        $display("FAIL rnd_state[%0d] got=f%b v%b c%b%b%b exp=f%b v%b c%b%b%b",
                 i, flags, out_valid, out_reg_write, out_mem_read,
                 out_mem_write, m_flags, m_valid, m_rw, m_mr, m_mw);
      end
      if (m_valid) begin
        total++;
        if (out_result !== m_result || out_store_data !== m_sd ||
            out_rd !== m_rd) begin
          bad++;
          $display("FAIL rnd_data[%0d] got=%h %h %0d exp=%h %h %0d",
                   i, out_result, out_store_data, out_rd,
                   m_result, m_sd, m_rd);
        end
      end
      total++;
      if (!out_valid &&
          (out_reg_write || out_mem_read || out_mem_write)) begin
        bad++;
        $display("FAIL rnd_gate[%0d] got=ctrl set while invalid exp=0", i);
      end
    end
    idle();
    tick();
  endtask

  initial begin
    m_flags = 4'b0; m_valid = 0; m_result = '0; m_sd = '0;
    m_rd = '0; m_rw = 0; m_mr = 0; m_mw = 0;
    idle();
    #1;
    test_reset();
    test_subs_blt();
    test_ands_logic();
    test_cbz_cbnz();
    test_stall_flush();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_flags_stage.md
Name: ex_flags_stage

Overview:
- Sits directly downstream of the 64-bit ALU in the execute stage of the 64-bit single-issue CPU.
- Owns the architectural NZCV flags register, which is updated only by flag-setting instructions.
- Evaluates branch decisions for B, CBZ, CBNZ and B.cond from the ALU flags and the stored flags.
- Registers the ALU result and control into the EX/MEM pipeline register, with stall and flush.

Parameters:
- WIDTH, 64, datapath width of the result and store data.
- REGW, 5, register-index width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- stall  in  1  hold all state; overrides in_valid.
- flush  in  1  squash the incoming instruction; lower priority than reset, higher than stall.
- in_valid  in  1  execute-stage instruction is valid.
- alu_result  in  WIDTH  ALU result.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags.
- set_flags  in  1  instruction writes NZCV (ADDS/SUBS/ANDS).
- flag_arith  in  1  1 = ALU add/sub, so C/V are meaningful; 0 = logic op.
- br_type  in  3  NONE / UNCOND / CBZ / CBNZ / BCOND.
- cond  in  4  ARMv8 condition code for BCOND.
- rd  in  REGW  destination register.
- reg_write, mem_read, mem_write  in  1 each  downstream control.
- store_data  in  WIDTH  data for memory store.
- br_taken  out  1  combinational taken decision for the PC mux.
- flags  out  4  registered NZCV, bit3=N, bit2=Z, bit1=C, bit0=V.
- out_valid  out  1  EX/MEM valid.
- out_result, out_store_data  out  WIDTH  registered copies.
- out_rd  out  REGW  registered copy.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered and gated by out_valid.

Behaviour:
- Reset (synchronous): flags=0000, out_valid=0, out_result=0, out_store_data=0, out_rd=0, and all out_* control=0. Reset wins over stall and flush.
- Effective update: upd = in_valid & ~flush & ~stall.
- Flags update on a clock edge with upd & set_flags:
  - N<=alu_negative, Z<=alu_zero.
  - If flag_arith, C<=alu_carry_out and V<=alu_overflow; otherwise C<=0 and V<=0.
  - Flags are otherwise held. Flags are never bypassed: a B.cond reads the registered flags, so an instruction that both sets flags and branches uses the old flags.
- br_taken (combinational, zero latency) is 0 unless in_valid & ~flush. Then:
  - NONE -> 0.
  - UNCOND -> 1.
  - CBZ -> alu_zero (ALU performs pass-B).
  - CBNZ -> ~alu_zero.
  - BCOND -> cond_eval(cond, flags).
  - Reserved br_type codes -> 0.
  - br_taken is not gated by stall; the PC logic qualifies it.
- cond_eval, with N,Z,C,V taken from the registered flags:
  - 0000 EQ Z; 0001 NE ~Z.
  - 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N.
  - 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~(C&~Z).
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE ~(~Z&(N==V)).
  - 1110 and 1111 always.
- Pipeline register, one-cycle latency:
  - stall: hold every register; flags are also held.
  - flush (no stall): out_valid<=0 and all out_* control<=0; data registers may load but are don't-care.
  - Otherwise: out_valid<=in_valid. Controls load ANDed with in_valid; data loads unconditionally.
  - flush & stall together: flush wins, i.e. the bubble is inserted and the flags are not updated.
- Invariant: out_reg_write, out_mem_read and out_mem_write are never 1 while out_valid=0.
- Reset mid-operation: the instruction held in the register is lost and the flags are cleared on the same edge.

Decomposition:
- Shared package cpu_pkg holds:
  - enum br_type_e: NONE=0, UNCOND=1, CBZ=2, CBNZ=3, BCOND=4.
  - localparams COND_EQ..COND_AL (4-bit).
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_eval: purely combinational, 4-bit cond plus 4-bit NZCV in, 1 bit out. It is reused later by CSEL.

Test Plan:
- Reset behaviour: assert reset for 2 cycles while in_valid=1 and set_flags=1 -> flags=0000, out_valid=0, all out_* control=0.
- SUBS then B.LT:
  - Cycle 1: alu_result=64'hFFFF_FFFF_FFFF_FFE7 (25-50), N=1, Z=0, C=0, V=0, set_flags=1, flag_arith=1 -> next cycle flags=1000.
  - Cycle 2: BCOND cond=1011 -> br_taken=1.
  - Repeat cycle 2 with cond=1010 -> br_taken=0.
- ANDS with logic flags: alu_carry_out=1, alu_overflow=1, alu_zero=1, flag_arith=0 -> flags=0100. Then B.EQ -> br_taken=1 and B.CS -> br_taken=0.
- CBZ/CBNZ with no flag update:
  - alu_zero=1 with CBZ -> br_taken=1; the same inputs with CBNZ -> br_taken=0.
  - flags are unchanged throughout.
  - With in_valid=0 and CBZ -> br_taken=0.
- Stall/flush on the pipeline register:
  - Load result 64'd75, rd=5, reg_write=1 -> out_valid=1 and out_result=75 one cycle later.
  - Then stall=1 for 3 cycles with new inputs -> outputs and flags hold their values.
  - Then flush=1 and stall=1 with set_flags=1 -> out_valid=0, out_reg_write=0, flags unchanged.
- Overflow flags: ADDS inputs producing V=1, C=1, N=0, Z=0 -> flags=0011. Then BCOND:
  - cond=0110 VS -> br_taken=1.
  - cond=1000 HI -> br_taken=1.
  - cond=1101 LE -> br_taken=1 (N!=V).
